// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg
//   Shared definitions for the elastic pipeline stages of the five-stage CPU.
//   It holds the bubble instruction word, the default field widths and the
//   stage-register state encoding.
package cpu_pipe_pkg;

    // The all-zero instruction word is the pipeline NOP used for bubbles.
    localparam logic [31:0] NOP_INS = 32'h0000_0000;

    localparam int PC_W_DEF   = 32;
    localparam int INS_W_DEF  = 32;
    localparam int DATA_W_DEF = 160;
    localparam int CNT_W_DEF  = 16;

    // EMPTY: nothing held. FULL: main register valid. SKID: main and skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
//   Saturating up-counter used for pipeline performance debug.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   synchronous, active-high; clears the count
//     en     in   count this cycle
//     count  out  current count, holds at all-ones
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic stage register placed between two CPU pipeline stages. It carries
//   the PC, the instruction word and an opaque payload bundle, with a
//   synchronous flush for bubble insertion and a saturating stall counter.
//
//   Handshake: a beat moves on an edge where valid && ready are both high on
//   the same side. in_valid/in_pc/in_ins/in_data must not depend on in_ready;
//   out_valid and out_* are registers and never depend on out_ready. With
//   SKID=1, in_ready is a register too, so no combinational path exists from
//   out_ready to in_ready; with SKID=0 in_ready = !out_valid || out_ready.
//
//   Ports:
//     clk, reset       clock and synchronous active-high reset
//     flush            drops every held entry on the next edge
//     in_valid/in_ready, in_pc/in_ins/in_data        upstream side
//     out_valid/out_ready, out_pc/out_ins/out_data   downstream side
//     occupancy        entries held (0..2, at most 1 with SKID=0)
//     stall_cnt        saturating count of edges with out_valid && !out_ready
module pipe_stage_elastic
    import cpu_pipe_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INS_W  = INS_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SKID   = 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INS_W-1:0]  in_ins,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INS_W-1:0]  out_ins,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Empty slots show a NOP bubble rather than stale contents.
    localparam logic [INS_W-1:0] BUBBLE_INS = INS_W'(NOP_INS);

    // Main (head) register, always the entry presented downstream.
    logic              m_valid;
    logic [PC_W-1:0]   m_pc;
    logic [INS_W-1:0]  m_ins;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        occ_q;
    logic              in_ready_w;

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_t       state;
            logic              rdy_q;
            logic [PC_W-1:0]   s_pc;
            logic [INS_W-1:0]  s_ins;
            logic [DATA_W-1:0] s_data;

            // Reset and flush clear the same registers; reset only differs in
            // also clearing the stall counter, which lives in the sub-module.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    state   <= ST_EMPTY;
                    rdy_q   <= 1'b1;
                    occ_q   <= 2'd0;
                    m_valid <= 1'b0;
                    m_pc    <= '0;
                    m_ins   <= BUBBLE_INS;
                    m_data  <= '0;
                    s_pc    <= '0;
                    s_ins   <= BUBBLE_INS;
                    s_data  <= '0;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (in_valid) begin
                                m_valid <= 1'b1;
                                m_pc    <= in_pc;
                                m_ins   <= in_ins;
                                m_data  <= in_data;
                                occ_q   <= 2'd1;
                                state   <= ST_FULL;
                            end
                        end
                        ST_FULL: begin
                            if (in_valid && out_ready) begin
                                // Pass-through: head leaves, new beat replaces it.
                                m_pc   <= in_pc;
                                m_ins  <= in_ins;
                                m_data <= in_data;
                            end else if (in_valid) begin
                                // Downstream stalled: park the beat in the skid
                                // register and close the input next cycle.
                                s_pc   <= in_pc;
                                s_ins  <= in_ins;
                                s_data <= in_data;
                                occ_q  <= 2'd2;
                                rdy_q  <= 1'b0;
                                state  <= ST_SKID;
                            end else if (out_ready) begin
                                m_valid <= 1'b0;
                                m_pc    <= '0;
                                m_ins   <= BUBBLE_INS;
                                m_data  <= '0;
                                occ_q   <= 2'd0;
                                state   <= ST_EMPTY;
                            end
                        end
                        ST_SKID: begin
                            if (out_ready) begin
                                m_pc   <= s_pc;
                                m_ins  <= s_ins;
                                m_data <= s_data;
                                s_pc   <= '0;
                                s_ins  <= BUBBLE_INS;
                                s_data <= '0;
                                occ_q  <= 2'd1;
                                rdy_q  <= 1'b1;
                                state  <= ST_FULL;
                            end
                        end
                        default: begin
                            state   <= ST_EMPTY;
                            rdy_q   <= 1'b1;
                            occ_q   <= 2'd0;
                            m_valid <= 1'b0;
                            m_pc    <= '0;
                            m_ins   <= BUBBLE_INS;
                            m_data  <= '0;
                        end
                    endcase
                end
            end

            assign in_ready_w = rdy_q;
        end else begin : g_single
            // Single entry: may accept when empty or when the head leaves now.
            assign in_ready_w = !m_valid || out_ready;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    occ_q   <= 2'd0;
                    m_valid <= 1'b0;
                    m_pc    <= '0;
                    m_ins   <= BUBBLE_INS;
                    m_data  <= '0;
                end else if (in_valid && in_ready_w) begin
                    occ_q   <= 2'd1;
                    m_valid <= 1'b1;
                    m_pc    <= in_pc;
                    m_ins   <= in_ins;
                    m_data  <= in_data;
                end else if (m_valid && out_ready) begin
                    occ_q   <= 2'd0;
                    m_valid <= 1'b0;
                    m_pc    <= '0;
                    m_ins   <= BUBBLE_INS;
                    m_data  <= '0;
                end
            end
        end
    endgenerate

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (m_valid && !out_ready),
        .count (stall_cnt)
    );

    assign in_ready  = in_ready_w;
    assign out_valid = m_valid;
    assign out_pc    = m_pc;
    assign out_ins   = m_ins;
    assign out_data  = m_data;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: instance dut uses SKID=1 with a 16-bit
// counter, instance dut0 uses SKID=0 with a 4-bit counter. Each has a
// scoreboard queue filled on accepted beats and drained on released beats.
module tb_pipe_stage_elastic;
    import cpu_pipe_pkg::*;

    localparam int PC_W   = 32;
    localparam int INS_W  = 32;
    localparam int DATA_W = 160;
    localparam int ENT_W  = PC_W + INS_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush;

    // SKID=1 instance signals
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [PC_W-1:0]   in_pc, out_pc;
    logic [INS_W-1:0]  in_ins, out_ins;
    logic [DATA_W-1:0] in_data, out_data;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    // SKID=0 instance signals
    logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [PC_W-1:0]   b_in_pc, b_out_pc;
    logic [INS_W-1:0]  b_in_ins, b_out_ins;
    logic [DATA_W-1:0] b_in_data, b_out_data;
    logic [1:0]        b_occupancy;
    logic [3:0]        b_stall_cnt;

    pipe_stage_elastic #(
        .PC_W(PC_W), .INS_W(INS_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ins(in_ins), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ins(out_ins), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_elastic #(
        .PC_W(PC_W), .INS_W(INS_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(4)
    ) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_pc(b_in_pc), .in_ins(b_in_ins), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_ins(b_out_ins), .out_data(b_out_data),
        .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scoreboards ----------------
    // At each falling edge: compare outputs against the model, then advance
    // the model with the inputs that the next rising edge will see.
    logic [ENT_W-1:0] exp_q[$];
    logic [ENT_W-1:0] b_exp_q[$];
    logic [15:0]      stall_model = '0;
    logic [3:0]       b_stall_model = '0;

    always @(negedge clk) begin
        automatic bit m_valid = (exp_q.size() != 0);
        automatic bit m_ready = (exp_q.size() < 2);
        if (mon_en) begin
            check("a_valid", out_valid, m_valid);
            check("a_occ", occupancy, exp_q.size());
            check("a_in_ready", in_ready, m_ready);
            check("a_stall", stall_cnt, stall_model);
            if (m_valid) check("a_head", {out_pc, out_ins, out_data}, exp_q[0]);
            else         check("a_bubble", {out_pc, out_ins, out_data}, '0);
        end
        if (reset) begin
            exp_q.delete();
            stall_model = '0;
        end else begin
            if (m_valid && !out_ready && stall_model != 16'hFFFF) stall_model++;
            if (flush) exp_q.delete();
            else begin
                if (m_valid && out_ready) void'(exp_q.pop_front());
                if (in_valid && m_ready) exp_q.push_back({in_pc, in_ins, in_data});
            end
        end
    end

    always @(negedge clk) begin
        automatic bit m_valid = (b_exp_q.size() != 0);
        automatic bit m_ready = (b_exp_q.size() == 0) || b_out_ready;
        if (mon_en) begin
            check("b_valid", b_out_valid, m_valid);
            check("b_occ", b_occupancy, b_exp_q.size());
            check("b_in_ready", b_in_ready, m_ready);
            check("b_stall", b_stall_cnt, b_stall_model);
            if (m_valid) check("b_head", {b_out_pc, b_out_ins, b_out_data}, b_exp_q[0]);
            else         check("b_bubble", {b_out_pc, b_out_ins, b_out_data}, '0);
        end
        if (reset) begin
            b_exp_q.delete();
            b_stall_model = '0;
        end else begin
            if (m_valid && !b_out_ready && b_stall_model != 4'hF) b_stall_model++;
            if (flush) b_exp_q.delete();
            else begin
                if (m_valid && b_out_ready) void'(b_exp_q.pop_front());
                if (b_in_valid && m_ready) b_exp_q.push_back({b_in_pc, b_in_ins, b_in_data});
            end
        end
    end

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after the rising edge; the task returns at
    // the following falling edge, where the caller may check outputs.
    task automatic step_a(input logic v, input logic [PC_W-1:0] pc, input logic rdy,
                          input logic fl, input logic rst);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_ins    = $urandom;
        in_data   = rand_data();
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        @(negedge clk);
    endtask

    task automatic step_b(input logic v, input logic [PC_W-1:0] pc, input logic rdy);
        @(posedge clk);
        #1;
        b_in_valid  = v;
        b_in_pc     = pc;
        b_in_ins    = $urandom;
        b_in_data   = rand_data();
        b_out_ready = rdy;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_pc = 32'h3000; in_ins = $urandom; in_data = rand_data();
        out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_pc = '0; b_in_ins = '0; b_in_data = '0; b_out_ready = 1'b1;

        // T1: reset held with a valid beat waiting upstream.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_rst_valid", out_valid, 1'b0);
        check("t1_rst_pc", out_pc, 32'h0);
        check("t1_rst_occ", occupancy, 2'd0);
        mon_en = 1'b1;

        // T1/T2: release reset while presenting pc 0x3000, then stream 8 beats.
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            check("t2_in_ready", in_ready, 1'b1);
            if (i == 1) begin
                check("t1_first_pc", out_pc, 32'h3000);
                check("t1_first_occ", occupancy, 2'd1);
            end
            if (i > 0) check("t2_order", out_pc, 32'h3000 + 32'(4 * (i - 1)));
        end
        step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t2_last_pc", out_pc, 32'h301C);
        step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t2_drained", out_valid, 1'b0);
        check("t2_stall", stall_cnt, 16'd0);

        // T3: downstream stalls while upstream keeps pushing.
        step_a(1'b1, 32'h3100, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 32'h3104, 1'b0, 1'b0, 1'b0);
        check("t3_occ1", occupancy, 2'd1);
        step_a(1'b1, 32'h3108, 1'b0, 1'b0, 1'b0);
        check("t3_occ2", occupancy, 2'd2);
        check("t3_not_ready", in_ready, 1'b0);
        step_a(1'b1, 32'h310C, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t3_stall3", stall_cnt, 16'd3);
        check("t3_head0", out_pc, 32'h3100);
        step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t3_head1", out_pc, 32'h3104);
        step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t3_empty", out_valid, 1'b0);

        // T4: flush while in SKID with a new beat offered.
        step_a(1'b1, 32'h3200, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 32'h3204, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 32'h4000, 1'b0, 1'b1, 1'b0);
        check("t4_pre_occ", occupancy, 2'd2);
        step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t4_valid", out_valid, 1'b0);
        check("t4_ins", out_ins, NOP_INS);
        check("t4_occ", occupancy, 2'd0);
        check("t4_ready", in_ready, 1'b1);
        check("t4_stall", stall_cnt, 16'd5);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("t4_no_4000", out_pc == 32'h4000, 1'b0);
        end

        // T5: flush alone keeps the counter; reset together with flush clears it.
        step_a(1'b0, '0, 1'b1, 1'b1, 1'b0);
        step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t5_flush_keeps", stall_cnt, 16'd5);
        step_a(1'b0, '0, 1'b1, 1'b1, 1'b1);
        step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t5_reset_clears", stall_cnt, 16'd0);
        check("t5_ready", in_ready, 1'b1);

        // T6: SKID=0 instance, long stall saturates the 4-bit counter.
        step_b(1'b1, 32'h5000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step_b(1'b1, 32'h5004 + 32'(4 * i), 1'b0);
            check("t6_occ_le1", b_occupancy <= 2'd1, 1'b1);
            check("t6_not_ready", b_in_ready, 1'b0);
        end
        check("t6_sat", b_stall_cnt, 4'd15);
        check("t6_head", b_out_pc, 32'h5000);
        step_b(1'b1, 32'h5100, 1'b1);
        check("t6_comb_ready", b_in_ready, 1'b1);
        step_b(1'b1, 32'h5104, 1'b1);
        check("t6_pass_pc", b_out_pc, 32'h5100);
        for (int i = 0; i < 3; i++) step_b(1'b0, '0, 1'b1);
        check("t6_drained", b_out_valid, 1'b0);
        check("t6_sat_hold", b_stall_cnt, 4'd15);

        // Random mixed traffic on both instances, checked by the scoreboards.
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            in_valid    = 1'($urandom_range(0, 1));
            in_pc       = $urandom;
            in_ins      = $urandom;
            in_data     = rand_data();
            out_ready   = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 31) == 0);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_pc     = $urandom;
            b_in_ins    = $urandom;
            b_in_data   = rand_data();
            b_out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; b_in_valid = 1'b0; flush = 1'b0;
        out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("end_empty_a", out_valid, 1'b0);
        check("end_empty_b", b_out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
